// File: rtl/mbssoc_mailbox.sv
// Inter-core mailbox: two receive FIFOs, per-core status/control registers and
// level interrupts, answering fixed-latency reads on the arbitrated RAM-side bus.
module mbssoc_mailbox #(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = 32'h0000_FF00,
    parameter int unsigned             FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic                  ram_re,
    input  logic                  ram_we,
    input  logic                  cpu_sel,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_oe,
    output logic [1:0]            irq
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [2][FIFO_DEPTH];

    logic [1:0][PW-1:0] wp, rp, wp_n, rp_n;
    logic [1:0][CW-1:0] cnt, cnt_n;
    logic [1:0]         ovf, udf, ien, ovf_n, udf_n, ien_n;
    logic [DATA_WIDTH-1:0] rdata_n;
    logic               oe_n;
    logic               push;

    logic       hit, wr, rd, c, p;
    logic [1:0] idx;
    logic       unused_addr_bits;

    assign hit = (ram_addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
    assign idx = ram_addr[3:2];
    assign c   = cpu_sel;
    assign p   = ~cpu_sel;
    // A simultaneous write wins; the read half is dropped
    assign wr  = hit & ram_we;
    assign rd  = hit & ram_re & ~ram_we;
    assign unused_addr_bits = ^ram_addr[1:0];

    // Next-state for FIFO bookkeeping, flags and the read-data register
    always_comb begin
        wp_n    = wp;
        rp_n    = rp;
        cnt_n   = cnt;
        ovf_n   = ovf;
        udf_n   = udf;
        ien_n   = ien;
        rdata_n = rdata;
        oe_n    = 1'b0;
        push    = 1'b0;

        if (wr) begin
            case (idx)
                2'd0: begin
                    if (cnt[p] == CW'(FIFO_DEPTH)) begin
                        ovf_n[c] = 1'b1;
                    end else begin
                        push     = 1'b1;
                        wp_n[p]  = wp[p] + PW'(1);
                        cnt_n[p] = cnt[p] + CW'(1);
                    end
                end
                2'd2: begin
                    ien_n[c] = wdata[0];
                    if (wdata[1]) begin
                        wp_n[c]  = '0;
                        rp_n[c]  = '0;
                        cnt_n[c] = '0;
                    end
                end
                default: ;
            endcase
        end else if (rd) begin
            oe_n = 1'b1;
            case (idx)
                2'd0: begin
                    if (cnt[c] == '0) begin
                        rdata_n  = '0;
                        udf_n[c] = 1'b1;
                    end else begin
                        rdata_n  = mem[c][rp[c]];
                        rp_n[c]  = rp[c] + PW'(1);
                        cnt_n[c] = cnt[c] - CW'(1);
                    end
                end
                2'd1: begin
                    rdata_n        = '0;
                    rdata_n[7:0]   = 8'(cnt[c]);
                    rdata_n[23:16] = 8'(CW'(FIFO_DEPTH) - cnt[p]);
                    rdata_n[30]    = udf[c];
                    rdata_n[31]    = ovf[c];
                    udf_n[c]       = 1'b0;
                    ovf_n[c]       = 1'b0;
                end
                2'd2:    rdata_n = DATA_WIDTH'(ien[c]);
                default: rdata_n = '0;
            endcase
        end
    end

    // FIFO storage carries no reset; contents are meaningless until pushed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[p][wp[p]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            ovf      <= '0;
            udf      <= '0;
            ien      <= '0;
            rdata    <= '0;
            rdata_oe <= 1'b0;
            irq      <= '0;
        end else begin
            wp       <= wp_n;
            rp       <= rp_n;
            cnt      <= cnt_n;
            ovf      <= ovf_n;
            udf      <= udf_n;
            ien      <= ien_n;
            rdata    <= rdata_n;
            rdata_oe <= oe_n;
            // Interrupt follows the post-access count at the same edge
            irq      <= ien_n & {(cnt_n[1] != '0), (cnt_n[0] != '0)};
        end
    end

endmodule

// File: tb/tb_mbssoc_mailbox.sv
// Directed plus randomized bench for mbssoc_mailbox against a queue-based mailbox model.
module tb_mbssoc_mailbox;

    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_FF00;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ram_addr = '0;
    logic          ram_re = 1'b0;
    logic          ram_we = 1'b0;
    logic          cpu_sel = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          rdata_oe;
    logic [1:0]    irq;

    always #5 clk = ~clk;

    mbssoc_mailbox #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ram_addr(ram_addr),
        .ram_re  (ram_re),
        .ram_we  (ram_we),
        .cpu_sel (cpu_sel),
        .wdata   (wdata),
        .rdata   (rdata),
        .rdata_oe(rdata_oe),
        .irq     (irq)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one queue per receive FIFO plus per-core flags
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    bit          ovf_m[2];
    bit          udf_m[2];
    bit          ien_m[2];
    logic [31:0] exp_rd = '0;
    bit          exp_oe = 1'b0;

    function automatic int qsize(bit i);
        return i ? q1.size() : q0.size();
    endfunction

    function automatic logic [31:0] exp_irq();
        return {30'd0, ien_m[1] && (qsize(1) != 0), ien_m[0] && (qsize(0) != 0)};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            ovf_m[i] = 1'b0;
            udf_m[i] = 1'b0;
            ien_m[i] = 1'b0;
        end
        exp_rd = '0;
        exp_oe = 1'b0;
    endtask

    task automatic model_step(bit sel, logic [31:0] addr, bit re, bit we, logic [31:0] wd);
        bit       c   = sel;
        bit       p   = !sel;
        bit       hit = (addr[31:4] == BASE[31:4]);
        int       ix  = int'(addr[3:2]);
        exp_oe = 1'b0;
        if (hit && we) begin
            if (ix == 0) begin
                if (qsize(p) == DEPTH) ovf_m[c] = 1'b1;
                else if (p) q1.push_back(wd);
                else q0.push_back(wd);
            end else if (ix == 2) begin
                ien_m[c] = wd[0];
                if (wd[1]) begin
                    if (c) q1.delete();
                    else q0.delete();
                end
            end
        end else if (hit && re) begin
            exp_oe = 1'b1;
            if (ix == 0) begin
                if (qsize(c) == 0) begin
                    exp_rd   = '0;
                    udf_m[c] = 1'b1;
                end else begin
                    exp_rd = c ? q1.pop_front() : q0.pop_front();
                end
            end else if (ix == 1) begin
                exp_rd = {ovf_m[c], udf_m[c], 6'd0, 8'(DEPTH - qsize(p)), 8'd0, 8'(qsize(c))};
                ovf_m[c] = 1'b0;
                udf_m[c] = 1'b0;
            end else if (ix == 2) begin
                exp_rd = {31'd0, ien_m[c]};
            end else begin
                exp_rd = '0;
            end
        end
    endtask

    task automatic access(bit sel, logic [31:0] addr, bit re, bit we, logic [31:0] wd, string tag);
        @(negedge clk);
        cpu_sel  = sel;
        ram_addr = addr;
        ram_re   = re;
        ram_we   = we;
        wdata    = wd;
        model_step(sel, addr, re, we, wd);
        @(posedge clk);
        #1;
        check({tag, ".oe"},    32'(rdata_oe), 32'(exp_oe));
        check({tag, ".rdata"}, rdata,         exp_rd);
        check({tag, ".irq"},   32'(irq),      exp_irq());
    endtask

    task automatic wr(bit sel, int ix, logic [31:0] d, string tag);
        access(sel, BASE + 32'(ix * 4), 1'b0, 1'b1, d, tag);
    endtask

    task automatic rd(bit sel, int ix, string tag);
        access(sel, BASE + 32'(ix * 4), 1'b1, 1'b0, '0, tag);
    endtask

    task automatic idle();
        access(1'b0, BASE, 1'b0, 1'b0, '0, "idle");
    endtask

    // Reset asserted in the middle of a read cycle must abort it
    task automatic mid_reset();
        @(negedge clk);
        cpu_sel  = 1'b0;
        ram_addr = BASE;
        ram_re   = 1'b1;
        ram_we   = 1'b0;
        #2 rst   = 1'b1;
        #1;
        check("rst.rdata", rdata,         32'd0);
        check("rst.oe",    32'(rdata_oe), 32'd0);
        check("rst.irq",   32'(irq),      32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst.oe_hold", 32'(rdata_oe), 32'd0);
        @(negedge clk);
        ram_re = 1'b0;
        rst    = 1'b0;
    endtask

    initial begin
        model_reset();
        #12 rst = 1'b0;

        // Reset state and first STATUS
        idle();
        rd(0, 1, "status_after_reset");
        check("status_after_reset.const", rdata, 32'h0008_0000);

        // Ping CPU0 -> CPU1
        wr(1, 2, 32'h1, "ien1");
        wr(0, 0, 32'hA5A5_0001, "ping_push");
        check("ping_irq1.const", 32'(irq[1]), 32'd1);
        rd(1, 0, "ping_pop");
        check("ping_pop.const", rdata, 32'hA5A5_0001);
        idle();

        // Fill RX1, overflow on the ninth word
        for (int i = 1; i <= 9; i++) wr(0, 0, 32'(i), "fill");
        rd(0, 1, "ovf_status");
        check("ovf_status.const", rdata, 32'h8000_0000);
        rd(0, 1, "ovf_status_clr");
        for (int i = 1; i <= 8; i++) rd(1, 0, "drain");
        for (int i = 0; i < 8; i++) begin
            wr(0, 0, 32'(100 + i), "wrap_push");
            rd(1, 0, "wrap_pop");
        end

        // Underflow on empty RX1
        rd(1, 0, "udf_pop");
        rd(1, 1, "udf_status");
        check("udf_status.const", rdata, 32'h4008_0000);
        rd(1, 1, "udf_status_clr");

        // Flush and write priority over read
        for (int i = 0; i < 3; i++) wr(1, 0, 32'($urandom), "post3");
        wr(0, 2, 32'h3, "flush0");
        check("flush0_irq0.const", 32'(irq[0]), 32'd0);
        rd(0, 1, "flush_status");
        access(1, BASE, 1'b1, 1'b1, 32'hDEAD_BEEF, "re_we_push");
        check("re_we_push.oe_const", 32'(rdata_oe), 32'd0);
        rd(0, 0, "re_we_pop");

        // Non-hit window
        access(0, BASE + 32'd16, 1'b1, 1'b0, '0, "nohit_rd");
        access(0, BASE + 32'd16, 1'b0, 1'b1, 32'h55, "nohit_wr");
        rd(0, 1, "nohit_status");

        mid_reset();
        rd(0, 1, "status_after_midrst");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit          sel = 1'($urandom_range(0, 1));
            int          ix  = int'($urandom_range(0, 3));
            bit          re  = 1'($urandom_range(0, 1));
            bit          we  = ($urandom_range(0, 2) == 0);
            logic [31:0] wd  = $urandom;
            logic [31:0] a   = BASE + 32'(ix * 4);
            if ($urandom_range(0, 9) == 0) a = a + 32'd16;
            if (ix == 2) begin
                wd[0] = 1'b1;
                wd[1] = ($urandom_range(0, 7) == 0);
            end
            if (n == 200) mid_reset();
            access(sel, a, re, we, wd, "rand");
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
